calc_seq_ctrl: RTL and testbench
================================

// Module: calc_seq_ctrl
// PURPOSE
//  Instruction sequencer for the small-calculator datapath. Accepts one instruction at a time.
//  Drives the 4x3-bit register file read/write ports and the ALU op select through a fixed FSM.
//  Reports completion and errors back to the front end (keypad/decoder).
//  Sits between the instruction source and the RF/ALU; contains no datapath storage itself.
// PARAMETERS
//  DW     3  data width (immediate operand, RF word)
//  AW     2  RF address width (2**AW registers)
//  CNT_W  8  width of completed-instruction counter
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      asynchronous, active-high reset
//  go         in   1      instruction valid; sampled only when busy=0
//  op         in   3      opcode (see BEHAVIOUR)
//  ra         in   AW     source A register
//  rb         in   AW     source B register
//  rd         in   AW     destination register
//  imm        in   DW     immediate for LOAD
//  busy       out  1      1 from cycle after go accept until DONE exits
//  done       out  1      one-cycle completion pulse
//  err        out  1      one-cycle pulse with done on reserved opcode
//  rea, reb   out  1      RF read enables
//  raa, rab   out  AW     RF read addresses
//  we         out  1      RF write enable
//  wa         out  AW     RF write address
//  din_sel    out  1      0 = ALU result to RF din, 1 = imm_q
//  imm_q      out  DW     latched immediate
//  alu_op     out  3      latched opcode to ALU
//  instr_cnt  out  CNT_W  completed-instruction count
// BEHAVIOUR
//  - Opcodes: 000 NOP, 001 LOAD, 010 MOV (A), 011 ADD, 100 SUB, 101 AND, 110 OR, 111 reserved.
//  - All outputs are registered (Moore); the RF read path is combinational, so the ALU sees data in the same cycle.
//  - Reset (async): state=IDLE; all outputs, latched fields and instr_cnt = 0.
//  - IDLE: busy=0. When go=1, latch op/ra/rb/rd/imm and select the next state:
//    - NOP -> DONE
//    - 111 -> DONE with err
//    - LOAD -> WRITE
//    - otherwise -> READ
//  - READ: rea=1, raa=ra_q; reb=1, rab=rb_q (reb=0 for MOV). alu_op valid. -> EXEC.
//  - EXEC: read enables and addresses held; ALU result settles. -> WRITE.
//  - WRITE: we=1, wa=rd_q.
//    - din_sel=1 for LOAD, else 0.
//    - Read enables held for ALU ops so din stays valid.
//    - -> DONE.
//  - DONE:
//    - done=1 for exactly one cycle; err=1 if op_q=111.
//    - instr_cnt += 1 on every done, including NOP and err.
//    - -> IDLE.
//  - Latency, go accept to done:
//    - ALU/MOV: 4 cycles
//    - LOAD: 2 cycles
//    - NOP/err: 1 cycle
//  - go while busy=1 is ignored (not queued). go in the same cycle done=1 is ignored.
//  - rea/reb/we are 0 in IDLE and DONE. we is high for exactly one cycle per LOAD/ALU/MOV instruction.
//  - rd may equal ra or rb: the write occurs at the WRITE edge, and the operands are already stable.
//  - instr_cnt wraps 2**CNT_W-1 -> 0 with no flag.
//  - Reset asserted mid-instruction aborts it immediately:
//    - we drops asynchronously; no partial write and no done.
//    - instr_cnt is cleared.
// STRUCTURE
//  - Shared package calc_pkg:
//    - opcode localparams OP_NOP..OP_RSVD
//    - FSM state encoding S_IDLE, S_READ, S_EXEC, S_WRITE, S_DONE
//  - One sub-module, calc_op_decode (combinational): op -> {uses_a, uses_b, is_load, is_nop, is_illegal}.
//  - The FSM, latches and counter stay in calc_seq_ctrl.
// TESTING
//  1. Reset then go, op=001, rd=2, imm=5:
//     - busy next cycle; WRITE with we=1, wa=2, din_sel=1, imm_q=5
//     - done 2 cycles after accept; instr_cnt=1
//  2. go, op=011, ra=1, rb=2, rd=3:
//     - READ rea=reb=1, raa=1, rab=2; then EXEC; then WRITE we=1, wa=3, din_sel=0, alu_op=011
//     - done 4 cycles after accept
//  3. op=111:
//     - done=1 and err=1 one cycle after accept
//     - no rea/reb/we asserted; instr_cnt increments
//  4. Second go pulsed during EXEC of an ADD, and go held during done:
//     - both ignored; exactly one we pulse and one done
//  5. rst asserted during EXEC of a SUB:
//     - all outputs 0 asynchronously; no we, no done; state IDLE after release
//  6. 256 NOPs back-to-back (go re-asserted each IDLE):
//     - instr_cnt wraps 255 -> 0; busy/done timing unchanged

Source files
------------

// File: rtl/calc_pkg.sv
// Shared definitions for the small-calculator instruction sequencer:
// datapath sizes, opcode values, FSM state encoding and the decode record.
package calc_pkg;

    localparam int CALC_DW    = 3;
    localparam int CALC_AW    = 2;
    localparam int CALC_CNT_W = 8;
    localparam int OP_W       = 3;

    localparam logic [OP_W-1:0] OP_NOP  = 3'b000;
    localparam logic [OP_W-1:0] OP_LOAD = 3'b001;
    localparam logic [OP_W-1:0] OP_MOV  = 3'b010;
    localparam logic [OP_W-1:0] OP_ADD  = 3'b011;
    localparam logic [OP_W-1:0] OP_SUB  = 3'b100;
    localparam logic [OP_W-1:0] OP_AND  = 3'b101;
    localparam logic [OP_W-1:0] OP_OR   = 3'b110;
    localparam logic [OP_W-1:0] OP_RSVD = 3'b111;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READ  = 3'd1;
    localparam logic [2:0] S_EXEC  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    // What an opcode needs from the register file and which path it takes.
    typedef struct packed {
        logic uses_a;
        logic uses_b;
        logic is_load;
        logic is_nop;
        logic is_illegal;
    } op_dec_t;

endpackage

// File: rtl/calc_seq_ctrl_if.sv
// Bundle between the instruction front end and the sequencer. The front
// end (master) issues instructions; the sequencer (slave) drives the
// RF/ALU control signals and status back out.
interface calc_seq_ctrl_if
    import calc_pkg::*;
#(
    parameter int DW    = CALC_DW,
    parameter int AW    = CALC_AW,
    parameter int CNT_W = CALC_CNT_W
);
    logic             go;
    logic [OP_W-1:0]  op;
    logic [AW-1:0]    ra;
    logic [AW-1:0]    rb;
    logic [AW-1:0]    rd;
    logic [DW-1:0]    imm;

    logic             busy;
    logic             done;
    logic             err;
    logic             rea;
    logic             reb;
    logic [AW-1:0]    raa;
    logic [AW-1:0]    rab;
    logic             we;
    logic [AW-1:0]    wa;
    logic             din_sel;
    logic [DW-1:0]    imm_q;
    logic [OP_W-1:0]  alu_op;
    logic [CNT_W-1:0] instr_cnt;

    modport master (
        output go, op, ra, rb, rd, imm,
        input  busy, done, err, rea, reb, raa, rab, we, wa,
               din_sel, imm_q, alu_op, instr_cnt
    );

    modport slave (
        input  go, op, ra, rb, rd, imm,
        output busy, done, err, rea, reb, raa, rab, we, wa,
               din_sel, imm_q, alu_op, instr_cnt
    );

endinterface

// File: rtl/calc_op_decode.sv
// Purely combinational opcode classifier used by the sequencer FSM.
module calc_op_decode
    import calc_pkg::*;
(
    input  logic [OP_W-1:0] op,
    output op_dec_t         dec
);

    // Map each opcode to its operand needs and control path.
    always_comb begin
        dec = '0;
        case (op)
            OP_NOP:  dec.is_nop = 1'b1;
            OP_LOAD: dec.is_load = 1'b1;
            OP_MOV:  dec.uses_a = 1'b1;
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                dec.uses_a = 1'b1;
                dec.uses_b = 1'b1;
            end
            OP_RSVD: dec.is_illegal = 1'b1;
            default: dec = '0;
        endcase
    end

endmodule

// File: rtl/calc_seq_ctrl.sv
// Instruction sequencer for the small-calculator datapath. Latches one
// instruction at a time and walks it through READ/EXEC/WRITE/DONE,
// driving registered (Moore) RF and ALU controls. Holds no datapath data.
module calc_seq_ctrl
    import calc_pkg::*;
#(
    parameter int DW    = CALC_DW,
    parameter int AW    = CALC_AW,
    parameter int CNT_W = CALC_CNT_W
)(
    input  logic           clk,
    input  logic           rst,
    calc_seq_ctrl_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    logic [2:0]       state_q, state_d;
    logic [OP_W-1:0]  op_q, op_d;
    logic [AW-1:0]    ra_q, ra_d;
    logic [AW-1:0]    rb_q, rb_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [DW-1:0]    imm_q, imm_d;

    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             rea_q, rea_d;
    logic             reb_q, reb_d;
    logic [AW-1:0]    raa_q, raa_d;
    logic [AW-1:0]    rab_q, rab_d;
    logic             we_q, we_d;
    logic [AW-1:0]    wa_q, wa_d;
    logic             din_sel_q, din_sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             accept;
    logic             in_rf_phase;
    op_dec_t          dec;

    // Decoding the next latched opcode lets the FSM branch on the incoming
    // instruction in IDLE and on the held one everywhere else.
    calc_op_decode u_decode (
        .op  (op_d),
        .dec (dec)
    );

    // Capture a new instruction only from IDLE; otherwise hold the fields.
    always_comb begin
        accept = (state_q == S_IDLE) && bus.go;
        op_d   = op_q;
        ra_d   = ra_q;
        rb_d   = rb_q;
        rd_d   = rd_q;
        imm_d  = imm_q;
        if (accept) begin
            op_d  = bus.op;
            ra_d  = bus.ra;
            rb_d  = bus.rb;
            rd_d  = bus.rd;
            imm_d = bus.imm;
        end
    end

    // Fixed instruction walk; NOP and reserved opcodes skip straight to DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.go) begin
                    if (dec.is_nop || dec.is_illegal) begin
                        state_d = S_DONE;
                    end else if (dec.is_load) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_READ:  state_d = S_EXEC;
            S_EXEC:  state_d = S_WRITE;
            S_WRITE: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are derived from the next state so they appear registered in
    // the same cycle the FSM enters that state.
    always_comb begin
        in_rf_phase = (state_d == S_READ) || (state_d == S_EXEC) || (state_d == S_WRITE);
        rea_d       = in_rf_phase && dec.uses_a;
        reb_d       = in_rf_phase && dec.uses_b;
        raa_d       = rea_d ? ra_d : '0;
        rab_d       = reb_d ? rb_d : '0;
        we_d        = (state_d == S_WRITE);
        wa_d        = we_d ? rd_d : '0;
        din_sel_d   = we_d && dec.is_load;
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
        err_d       = done_d && dec.is_illegal;
        cnt_d       = done_d ? (cnt_q + CNT_ONE) : cnt_q;
    end

    // State, latched instruction, registered controls and the counter;
    // reset aborts any instruction in flight and clears everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            ra_q      <= '0;
            rb_q      <= '0;
            rd_q      <= '0;
            imm_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            rea_q     <= 1'b0;
            reb_q     <= 1'b0;
            raa_q     <= '0;
            rab_q     <= '0;
            we_q      <= 1'b0;
            wa_q      <= '0;
            din_sel_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            ra_q      <= ra_d;
            rb_q      <= rb_d;
            rd_q      <= rd_d;
            imm_q     <= imm_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            rea_q     <= rea_d;
            reb_q     <= reb_d;
            raa_q     <= raa_d;
            rab_q     <= rab_d;
            we_q      <= we_d;
            wa_q      <= wa_d;
            din_sel_q <= din_sel_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.rea       = rea_q;
    assign bus.reb       = reb_q;
    assign bus.raa       = raa_q;
    assign bus.rab       = rab_q;
    assign bus.we        = we_q;
    assign bus.wa        = wa_q;
    assign bus.din_sel   = din_sel_q;
    assign bus.imm_q     = imm_q;
    assign bus.alu_op    = op_q;
    assign bus.instr_cnt = cnt_q;

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Self-checking bench for calc_seq_ctrl: a table of single instructions
// with hand-computed results, plus hand-written sequences for ignored go,
// mid-instruction reset and counter wrap.
module tb_calc_seq_ctrl;

    logic clk;
    logic rst;

    int total;
    int bad;
    logic [7:0] expCnt;

    typedef struct {
        logic [2:0] op;
        logic [1:0] ra;
        logic [1:0] rb;
        logic [1:0] rd;
        logic [2:0] imm;
        int         expLat;
        int         expWe;
        logic [1:0] expWa;
        logic       expDinSel;
        int         expReaCyc;
        int         expRebCyc;
        logic [1:0] expRaa;
        logic [1:0] expRab;
        logic       expErr;
    } vec_t;

    vec_t vecs[9];

    int         obsLat;
    int         obsWe;
    logic [1:0] obsWa;
    logic       obsDinSel;
    logic [2:0] obsImm;
    int         obsReaCyc;
    int         obsRebCyc;
    logic [1:0] obsRaa;
    logic [1:0] obsRab;
    logic       obsErr;
    logic [7:0] obsCnt;
    logic [2:0] obsAluOp;
    logic       obsBusy1;
    logic       obsDoneQuiet;

    calc_seq_ctrl_if bus ();

    calc_seq_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the sequence itself wedges.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0d want=%0d", name, act, exp);
        end
    endtask

    function automatic int allOutputs();
        return int'({bus.busy, bus.done, bus.err, bus.rea, bus.reb, bus.raa, bus.rab,
                     bus.we, bus.wa, bus.din_sel, bus.imm_q, bus.alu_op, bus.instr_cnt});
    endfunction

    // Issue one instruction and record what the sequencer does until done.
    task automatic applyStimulus(input vec_t v);
        obsLat = -1; obsWe = 0; obsWa = 0; obsDinSel = 0; obsImm = 0;
        obsReaCyc = 0; obsRebCyc = 0; obsRaa = 0; obsRab = 0;
        obsErr = 0; obsCnt = 0; obsAluOp = 0; obsDoneQuiet = 0;
        @(negedge clk);
        bus.go = 1'b1; bus.op = v.op; bus.ra = v.ra; bus.rb = v.rb; bus.rd = v.rd; bus.imm = v.imm;
        @(negedge clk);
        bus.go = 1'b0; bus.op = ~v.op; bus.ra = ~v.ra; bus.rb = ~v.rb; bus.rd = ~v.rd; bus.imm = ~v.imm;
        obsBusy1 = bus.busy;
        for (int c = 1; c <= 12; c++) begin
            if (c > 1) @(negedge clk);
            if (bus.rea) begin
                if (obsReaCyc == 0) obsRaa = bus.raa;
                obsReaCyc++;
            end
            if (bus.reb) begin
                if (obsRebCyc == 0) obsRab = bus.rab;
                obsRebCyc++;
            end
            if (bus.we) begin
                obsWe++;
                obsWa = bus.wa;
                obsDinSel = bus.din_sel;
                obsImm = bus.imm_q;
            end
            if (bus.done) begin
                obsLat = c;
                obsErr = bus.err;
                obsCnt = bus.instr_cnt;
                obsAluOp = bus.alu_op;
                obsDoneQuiet = !(bus.rea || bus.reb || bus.we);
                break;
            end
        end
    endtask

    // Run one table entry and compare everything it produced.
    task automatic runVector(input int idx);
        vec_t v;
        string tag;
        v = vecs[idx];
        tag = $sformatf("v%0d", idx);
        applyStimulus(v);
        expCnt = expCnt + 8'd1;
        checkOutput({tag, "_busy1"}, int'(obsBusy1), 1);
        checkOutput({tag, "_latency"}, obsLat, v.expLat);
        checkOutput({tag, "_we_pulses"}, obsWe, v.expWe);
        checkOutput({tag, "_wa"}, int'(obsWa), int'(v.expWa));
        checkOutput({tag, "_din_sel"}, int'(obsDinSel), int'(v.expDinSel));
        checkOutput({tag, "_rea_cycles"}, obsReaCyc, v.expReaCyc);
        checkOutput({tag, "_reb_cycles"}, obsRebCyc, v.expRebCyc);
        checkOutput({tag, "_raa"}, int'(obsRaa), int'(v.expRaa));
        checkOutput({tag, "_rab"}, int'(obsRab), int'(v.expRab));
        checkOutput({tag, "_err"}, int'(obsErr), int'(v.expErr));
        checkOutput({tag, "_instr_cnt"}, int'(obsCnt), int'(expCnt));
        checkOutput({tag, "_alu_op"}, int'(obsAluOp), int'(v.op));
        checkOutput({tag, "_done_quiet"}, int'(obsDoneQuiet), 1);
        if (v.expWe > 0) checkOutput({tag, "_imm_q"}, int'(obsImm), int'(v.imm));
        @(negedge clk);
        checkOutput({tag, "_idle_busy"}, int'(bus.busy), 0);
        checkOutput({tag, "_done_once"}, int'(bus.done), 0);
    endtask

    initial begin
        int weSeen;
        int doneSeen;
        int busySeen;
        int doneAt;

        total = 0;
        bad = 0;
        expCnt = 8'd0;

        //            op      ra    rb    rd    imm   lat we wa  ds  rea reb raa  rab  err
        vecs[0] = '{3'b001, 2'd0, 2'd0, 2'd2, 3'd5, 2, 1, 2'd2, 1'b1, 0, 0, 2'd0, 2'd0, 1'b0};
        vecs[1] = '{3'b011, 2'd1, 2'd2, 2'd3, 3'd0, 4, 1, 2'd3, 1'b0, 3, 3, 2'd1, 2'd2, 1'b0};
        vecs[2] = '{3'b111, 2'd1, 2'd1, 2'd1, 3'd3, 1, 0, 2'd0, 1'b0, 0, 0, 2'd0, 2'd0, 1'b1};
        vecs[3] = '{3'b000, 2'd2, 2'd3, 2'd1, 3'd4, 1, 0, 2'd0, 1'b0, 0, 0, 2'd0, 2'd0, 1'b0};
        vecs[4] = '{3'b010, 2'd3, 2'd2, 2'd0, 3'd1, 4, 1, 2'd0, 1'b0, 3, 0, 2'd3, 2'd0, 1'b0};
        vecs[5] = '{3'b100, 2'd2, 2'd2, 2'd2, 3'd6, 4, 1, 2'd2, 1'b0, 3, 3, 2'd2, 2'd2, 1'b0};
        vecs[6] = '{3'b101, 2'd0, 2'd3, 2'd1, 3'd2, 4, 1, 2'd1, 1'b0, 3, 3, 2'd0, 2'd3, 1'b0};
        vecs[7] = '{3'b110, 2'd3, 2'd1, 2'd3, 3'd0, 4, 1, 2'd3, 1'b0, 3, 3, 2'd3, 2'd1, 1'b0};
        vecs[8] = '{3'b001, 2'd2, 2'd1, 2'd0, 3'd7, 2, 1, 2'd0, 1'b1, 0, 0, 2'd0, 2'd0, 1'b0};

        rst = 1'b1;
        bus.go = 1'b0; bus.op = 3'd0; bus.ra = 2'd0; bus.rb = 2'd0; bus.rd = 2'd0; bus.imm = 3'd0;
        repeat (3) @(negedge clk);
        checkOutput("reset_outputs", allOutputs(), 0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_reset_idle", allOutputs(), 0);

        $display("[TB] single-instruction table");
        for (int i = 0; i < 9; i++) runVector(i);

        // ADD with a stray go during EXEC and go held through DONE.
        $display("[TB] ignored go during busy and done");
        @(negedge clk);
        bus.go = 1'b1; bus.op = 3'b011; bus.ra = 2'd1; bus.rb = 2'd2; bus.rd = 2'd3;
        weSeen = 0; doneSeen = 0; busySeen = 0; doneAt = -1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (bus.we) weSeen++;
            if (bus.done) begin
                doneSeen++;
                doneAt = c;
            end
            if (c >= 5 && bus.busy) busySeen++;
            bus.go = 1'b0;
            if (c == 2) begin
                bus.go = 1'b1; bus.op = 3'b001; bus.rd = 2'd1; bus.imm = 3'd6;
            end
            if (c == 4) begin
                bus.go = 1'b1; bus.op = 3'b000;
            end
        end
        expCnt = expCnt + 8'd1;
        checkOutput("ignore_we_pulses", weSeen, 1);
        checkOutput("ignore_done_pulses", doneSeen, 1);
        checkOutput("ignore_done_cycle", doneAt, 4);
        checkOutput("ignore_busy_after", busySeen, 0);
        checkOutput("ignore_instr_cnt", int'(bus.instr_cnt), int'(expCnt));

        // SUB aborted by reset during EXEC.
        $display("[TB] reset during EXEC");
        @(negedge clk);
        bus.go = 1'b1; bus.op = 3'b100; bus.ra = 2'd3; bus.rb = 2'd0; bus.rd = 2'd1;
        @(negedge clk);
        bus.go = 1'b0;
        @(negedge clk);
        checkOutput("abort_exec_rea", int'(bus.rea), 1);
        #2 rst = 1'b1;
        #1 checkOutput("abort_async_clear", allOutputs(), 0);
        @(negedge clk);
        rst = 1'b0;
        expCnt = 8'd0;
        weSeen = 0; doneSeen = 0; busySeen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus.we) weSeen++;
            if (bus.done) doneSeen++;
            if (bus.busy) busySeen++;
        end
        checkOutput("abort_no_we", weSeen, 0);
        checkOutput("abort_no_done", doneSeen, 0);
        checkOutput("abort_idle", busySeen, 0);
        checkOutput("abort_cnt_cleared", int'(bus.instr_cnt), 0);
        runVector(3);

        // Back-to-back NOPs from a fresh reset to exercise counter wrap.
        $display("[TB] counter wrap with back-to-back NOPs");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        expCnt = 8'd0;
        bus.op = 3'b000;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            checkOutput("nop_idle_busy", int'(bus.busy), 0);
            bus.go = 1'b1;
            @(negedge clk);
            bus.go = 1'b0;
            expCnt = expCnt + 8'd1;
            checkOutput("nop_done", int'(bus.done), 1);
            checkOutput("nop_busy", int'(bus.busy), 1);
            checkOutput("nop_cnt", int'(bus.instr_cnt), int'(expCnt));
            if (i == 254) checkOutput("nop_cnt_max", int'(bus.instr_cnt), 255);
        end
        checkOutput("nop_cnt_wrapped", int'(bus.instr_cnt), 0);
        @(negedge clk);
        checkOutput("nop_final_idle", int'(bus.busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
